// File: rtl/snake_motion.sv
// Snake movement stage: step pacing, direction latching and the 20-segment position history.
// Optional macro SNAKE_SPEEDUP_EN shortens the step period as the score rises.
module snake_motion #(
    parameter int STEP_DIV = 2_500_000,
    parameter int GRID     = 10,
    parameter int START_X  = 320,
    parameter int START_Y  = 240
) (
    input  logic         vga_clk,
    input  logic         reset,
    input  logic         btn_up,
    input  logic         btn_down,
    input  logic         btn_left,
    input  logic         btn_right,
    input  logic         btn_start,
    input  logic         grow,
    input  logic         GameOver,
    output logic [9:0]   snakex,
    output logic [9:0]   snakey,
    output logic [199:0] storex,
    output logic [199:0] storey,
    output logic [7:0]   score,
    output logic         step,
    output logic         running
);

    localparam int CW = $clog2(STEP_DIV);

    typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;
    typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} dir_t;

    function automatic logic [199:0] init_x();
        logic [199:0] v;
        v = '0;
        for (int unsigned k = 0; k < 20; k++)
            v[10*k +: 10] = 10'(START_X - GRID * int'(k));
        return v;
    endfunction

    function automatic logic [199:0] init_y();
        logic [199:0] v;
        v = '0;
        for (int unsigned k = 0; k < 20; k++)
            v[10*k +: 10] = 10'(START_Y);
        return v;
    endfunction

    function automatic logic opposite(dir_t a, dir_t b);
        logic r;
        case (a)
            UP:      r = (b == DOWN);
            DOWN:    r = (b == UP);
            LEFT:    r = (b == RIGHT);
            default: r = (b == LEFT);
        endcase
        return r;
    endfunction

    localparam logic [199:0] INIT_X = init_x();
    localparam logic [199:0] INIT_Y = init_y();

    state_t        state, state_next;
    dir_t          dir, pending, req_now, dir_next;
    logic [CW-1:0] cnt;
    logic          at_end, take_step, start_run;
    logic [9:0]    hx_next, hy_next;

    always_ff @(posedge vga_clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (btn_start) state_next = RUN;
            RUN:     if (GameOver)  state_next = DEAD;
            DEAD:    if (!btn_start) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

`ifdef SNAKE_SPEEDUP_EN
    logic [4:0]    sc;
    logic [CW-1:0] period_m1;
    always_comb begin
        sc        = (score > 8'd18) ? 5'd18 : score[4:0];
        period_m1 = CW'(STEP_DIV - 1 - int'(sc) * (STEP_DIV >> 5));
        // >= rather than == so a shortened period still fires if the count is already past it
        at_end    = (cnt >= period_m1);
    end
`else
    assign at_end = (cnt == CW'(STEP_DIV - 1));
`endif

    always_comb begin
        req_now = pending;
        if (btn_up)         req_now = UP;
        else if (btn_down)  req_now = DOWN;
        else if (btn_left)  req_now = LEFT;
        else if (btn_right) req_now = RIGHT;

        dir_next  = opposite(req_now, dir) ? dir : req_now;
        start_run = (state == IDLE) && btn_start;
        take_step = (state == RUN) && !GameOver && at_end;

        hx_next = storex[9:0];
        hy_next = storey[9:0];
        case (dir_next)
            UP:      hy_next = storey[9:0] - 10'(GRID);
            DOWN:    hy_next = storey[9:0] + 10'(GRID);
            LEFT:    hx_next = storex[9:0] - 10'(GRID);
            default: hx_next = storex[9:0] + 10'(GRID);
        endcase
    end

    always_ff @(posedge vga_clk) begin
        step <= 1'b0;
        if (reset || start_run) begin
            storex  <= INIT_X;
            storey  <= INIT_Y;
            dir     <= RIGHT;
            score   <= '0;
            cnt     <= '0;
            pending <= reset ? RIGHT : req_now;
        end else begin
            pending <= req_now;
            if (state == RUN) begin
                if (grow && score != 8'hFF) score <= score + 8'd1;
                if (!GameOver) begin
                    if (at_end) begin
                        cnt     <= '0;
                        step    <= 1'b1;
                        dir     <= dir_next;
                        // Committed direction replaces the request so a discarded reversal cannot resurface later
                        pending <= dir_next;
                        storex  <= {storex[189:0], hx_next};
                        storey  <= {storey[189:0], hy_next};
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            end
        end
    end

    assign snakex  = storex[9:0];
    assign snakey  = storey[9:0];
    assign running = (state == RUN);

    logic unused;
    assign unused = take_step;

endmodule
